// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory controller and its RAM.
package riscv_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // True when every address bit above the word index is zero.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input int unsigned addr_w);
        return (addr >> (addr_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/riscv_dmem_ctrl_if.sv
// Data bus between the memory stage (master) and the data-memory controller (slave).
interface riscv_dmem_ctrl_if;
    import riscv_mem_pkg::*;

    logic            i_req;
    logic            i_we;
    logic [XLEN-1:0] i_addr;
    logic [BE_W-1:0] i_be;
    logic [XLEN-1:0] i_wdata;
    logic            o_gnt;
    logic            o_rvalid;
    logic [XLEN-1:0] o_rdata;
    logic            o_err;

    modport master (
        output i_req,
        output i_we,
        output i_addr,
        output i_be,
        output i_wdata,
        input  o_gnt,
        input  o_rvalid,
        input  o_rdata,
        input  o_err
    );

    modport slave (
        input  i_req,
        input  i_we,
        input  i_addr,
        input  i_be,
        input  i_wdata,
        output o_gnt,
        output o_rvalid,
        output o_rdata,
        output o_err
    );

endinterface

// File: rtl/riscv_sram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module riscv_sram_be
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [XLEN-1:0] mem [Depth];
    logic [XLEN-1:0] rdata_q;

    // Read data is only updated by a load, so it holds across stores and idle cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (be[k]) begin
                        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory slave: accepts one load/store at a time, waits WAIT_CYCLES, commits to the
// byte-writable RAM on the edge entering RESP and returns a one-cycle response.
module riscv_dmem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    riscv_dmem_ctrl_if.slave   bus
);

    localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    dmem_req_t       req_q, req_d;
    logic            err_q, err_d;
    logic            rsel_q, rsel_d;
    logic            gnt;
    logic            rvalid;
    logic            in_range;
    logic            ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [XLEN-1:0] ram_rdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        err_d    = err_q;
        rsel_d   = rsel_q;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        in_range = 1'b0;
        ram_en   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt = 1'b1;
                if (bus.i_req) begin
                    req_d.we    = bus.i_we;
                    req_d.addr  = bus.i_addr;
                    req_d.be    = bus.i_be;
                    req_d.wdata = bus.i_wdata;
                    cnt_d       = WaitLoad;
                    state_d     = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rvalid  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Commit on the edge entering RESP; with zero wait states that is the accept edge,
        // hence the RAM is fed from req_d rather than req_q.
        if (state_d == RESP && state_q != RESP) begin
            in_range = addr_in_range(req_d.addr, ADDR_W);
            ram_en   = in_range;
            err_d    = !in_range;
            rsel_d   = in_range && !req_d.we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rsel_q  <= rsel_d;
        end
    end

    assign ram_addr = req_d.addr[ADDR_W+1:2];

    riscv_sram_be #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (req_d.we),
        .be    (req_d.be),
        .addr  (ram_addr),
        .wdata (req_d.wdata),
        .rdata (ram_rdata)
    );

    // Stores and errors read back as zero; the select register makes that hold between responses.
    assign bus.o_gnt    = gnt;
    assign bus.o_rvalid = rvalid;
    assign bus.o_rdata  = rsel_q ? ram_rdata : '0;
    assign bus.o_err    = err_q;

endmodule
